// File: rtl/flash_pkg.sv
// Shared types and constants for the NOR flash word reader.
package flash_pkg;

    typedef enum logic [2:0] {
        ST_RST_HOLD = 3'd0,
        ST_RST_REC  = 3'd1,
        ST_IDLE     = 3'd2,
        ST_RD_LO    = 3'd3,
        ST_RD_HI    = 3'd4
    } fl_state_e;

    localparam int FL_ACCESS_CYCLES_DEF = 6;
    localparam int FL_PAGE_CYCLES_DEF   = 2;
    localparam int FL_RST_CYCLES_DEF    = 25;

    // Byte-lane index is the value driven on flash A0.
    localparam logic FL_LANE_LO = 1'b0;
    localparam logic FL_LANE_HI = 1'b1;

    function automatic int fl_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/flash_reader.sv
// Two-byte word reader for an 8-bit NOR flash with power-up reset sequencing.
// Optional FL_PAGE_MODE_EN shortens the second-byte access to PAGE_CYCLES.
import flash_pkg::*;

module flash_reader #(
    parameter int ACCESS_CYCLES = FL_ACCESS_CYCLES_DEF,
    parameter int PAGE_CYCLES   = FL_PAGE_CYCLES_DEF,
    parameter int RST_CYCLES    = FL_RST_CYCLES_DEF
) (
    input  logic        iclk,
    input  logic        ireset,
    input  logic [22:0] ifl_addr,
    input  logic        ifl_req,
    output logic        ofl_ack,
    output logic [15:0] ofl_data,
    output logic        ordy,
    output logic [22:0] ofl_a,
    input  logic [7:0]  ifl_dq,
    output logic        ofl_ce_n,
    output logic        ofl_oe_n,
    output logic        ofl_we_n,
    output logic        ofl_rst_n,
    output logic        ofl_wp_n
);

    // One shared counter; sized so every phase (including page mode) fits.
    localparam int CNT_W = $clog2(fl_max3(ACCESS_CYCLES, RST_CYCLES, PAGE_CYCLES) + 1);
    localparam logic [CNT_W-1:0] ACC_LAST = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
`ifdef FL_PAGE_MODE_EN
    localparam logic [CNT_W-1:0] HI_LAST  = CNT_W'(PAGE_CYCLES - 1);
`else
    localparam logic [CNT_W-1:0] HI_LAST  = CNT_W'(ACCESS_CYCLES - 1);
`endif

    fl_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       lo_q;
    logic [15:0]      data_q;
    logic             ack_q;
    logic [22:0]      a_q;
    logic             ce_n_q;
    logic             oe_n_q;
    logic             rst_n_q;
    logic             rdy_q;
    logic             unused_addr_lsb_s;

    assign unused_addr_lsb_s = ifl_addr[0];

    // Reset sequencing and word-read FSM with registered pin/handshake outputs.
    always_ff @(posedge iclk) begin
        if (ireset) begin
            state_q <= ST_RST_HOLD;
            cnt_q   <= '0;
            lo_q    <= 8'h00;
            data_q  <= 16'h0000;
            ack_q   <= 1'b0;
            a_q     <= 23'h000000;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            rst_n_q <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_RST_HOLD: begin
                    if (cnt_q == RST_LAST) begin
                        cnt_q   <= '0;
                        rst_n_q <= 1'b1;
                        state_q <= ST_RST_REC;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RST_REC: begin
                    if (cnt_q == RST_LAST) begin
                        cnt_q   <= '0;
                        rdy_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (ifl_req != ack_q) begin
                        a_q     <= {ifl_addr[22:1], FL_LANE_LO};
                        ce_n_q  <= 1'b0;
                        oe_n_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_RD_LO;
                    end
                end
                ST_RD_LO: begin
                    if (cnt_q == ACC_LAST) begin
                        lo_q    <= ifl_dq;
                        a_q[0]  <= FL_LANE_HI;
                        cnt_q   <= '0;
                        state_q <= ST_RD_HI;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RD_HI: begin
                    // Ack mirrors the live req level, so extra toggles collapse into this access.
                    if (cnt_q == HI_LAST) begin
                        data_q  <= {ifl_dq, lo_q};
                        ack_q   <= ifl_req;
                        ce_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_RST_HOLD;
                    cnt_q   <= '0;
                    ce_n_q  <= 1'b1;
                    oe_n_q  <= 1'b1;
                    rst_n_q <= 1'b0;
                    rdy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign ofl_ack   = ack_q;
    assign ofl_data  = data_q;
    assign ordy      = rdy_q;
    assign ofl_a     = a_q;
    assign ofl_ce_n  = ce_n_q;
    assign ofl_oe_n  = oe_n_q;
    assign ofl_rst_n = rst_n_q;
    assign ofl_we_n  = 1'b1;
    assign ofl_wp_n  = 1'b0;

endmodule

// File: tb/tb_flash_reader.sv
// Randomized scoreboard bench for flash_reader with a behavioural flash and word model.
`timescale 1ns/1ps
module tb_flash_reader;

    localparam int ACC  = 6;
    localparam int RSTC = 25;
`ifdef FL_PAGE_MODE_EN
    localparam int HI   = 2;
`else
    localparam int HI   = 6;
`endif
    localparam int LAT  = ACC + HI;

    logic        iclk = 1'b0;
    logic        ireset = 1'b1;
    logic [22:0] ifl_addr = 23'h000000;
    logic        ifl_req = 1'b0;
    logic        ofl_ack;
    logic [15:0] ofl_data;
    logic        ordy;
    logic [22:0] ofl_a;
    logic [7:0]  ifl_dq;
    logic        ofl_ce_n, ofl_oe_n, ofl_we_n, ofl_rst_n, ofl_wp_n;

    flash_reader dut (
        .iclk(iclk), .ireset(ireset), .ifl_addr(ifl_addr), .ifl_req(ifl_req),
        .ofl_ack(ofl_ack), .ofl_data(ofl_data), .ordy(ordy), .ofl_a(ofl_a),
        .ifl_dq(ifl_dq), .ofl_ce_n(ofl_ce_n), .ofl_oe_n(ofl_oe_n),
        .ofl_we_n(ofl_we_n), .ofl_rst_n(ofl_rst_n), .ofl_wp_n(ofl_wp_n)
    );

    always #5 iclk = ~iclk;

    int cyc = 0;
    always @(posedge iclk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    bit in_rst = 1'b1;

    typedef struct {
        logic [15:0] data;
        logic        ack;
        int          when;
    } exp_t;
    exp_t sb[$];

    // Flash contents: a few fixed cells, everything else a fixed hash of the address.
    function automatic logic [7:0] fl_byte(input logic [22:0] a);
        case (a)
            23'h000200: return 8'h12;
            23'h000201: return 8'h34;
            23'h7FFFFE: return 8'hC3;
            23'h7FFFFF: return 8'h5E;
            default:    return a[7:0] ^ {a[14:8], a[22]} ^ a[22:15] ^ 8'hA5;
        endcase
    endfunction

    function automatic logic [15:0] ref_word(input logic [22:0] a);
        logic [22:0] base;
        base = a & 23'h7FFFFE;
        return {fl_byte(base + 23'd1), fl_byte(base)};
    endfunction

    assign ifl_dq = ofl_oe_n ? 8'hFF : fl_byte(ofl_a);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ack toggle pops one expectation; data must hold between acks.
    initial begin
        logic        prev_ack;
        logic [15:0] last;
        exp_t        e;
        prev_ack = 1'b0;
        last = 16'h0000;
        forever begin
            @(negedge iclk);
            if (in_rst || ireset) begin
                prev_ack = ofl_ack;
                last = ofl_data;
            end else if (ofl_ack !== prev_ack) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_ack: ack=%0b with empty scoreboard (cycle %0d)", ofl_ack, cyc);
                end else begin
                    e = sb.pop_front();
                    check("ack_data", 32'(ofl_data), 32'(e.data));
                    check("ack_level", 32'(ofl_ack), 32'(e.ack));
                    check("ack_cycle", 32'(cyc), 32'(e.when));
                end
                prev_ack = ofl_ack;
                last = ofl_data;
            end else begin
                check("data_hold", 32'(ofl_data), 32'(last));
            end
        end
    end

    task automatic wait_ack();
        int k;
        k = 0;
        while (ofl_ack !== ifl_req && k < 60) begin
            @(negedge iclk);
            k++;
        end
        if (k == 60) begin
            n_vec++;
            n_err++;
            $display("FAIL ack_timeout: ack=%0b, expected %0b", ofl_ack, ifl_req);
        end
    endtask

    // Issue one read at a negedge with the DUT idle; mode[0] scrambles addr, mode[1] double-toggles req.
    task automatic do_read(input logic [22:0] addr, input int mode);
        int          t0;
        logic [22:0] even;
        even = addr & 23'h7FFFFE;
        ifl_addr = addr;
        ifl_req = ~ifl_req;
        t0 = cyc;
        sb.push_back('{ref_word(addr), ifl_req, t0 + 1 + LAT});
        @(negedge iclk);
        check("addr_lo", 32'(ofl_a), 32'(even));
        check("ce_oe_on", 32'({ofl_ce_n, ofl_oe_n}), 32'd0);
        for (int i = 2; i <= LAT; i++) begin
            @(negedge iclk);
            if (mode[0] && i == 2) ifl_addr = 23'($urandom);
            if (mode[1] && (i == 3 || i == 5)) ifl_req = ~ifl_req;
            if (i == ACC) check("addr_lo_hold", 32'(ofl_a), 32'(even));
            if (i == ACC + 1) check("addr_hi", 32'(ofl_a), 32'(even | 23'd1));
        end
        wait_ack();
    endtask

    // Assert reset now (at a negedge), then verify the flash reset timeline.
    task automatic do_reset(input bit early_req);
        int rel, rst_hi, rdy_at;
        bit ce_ok;
        ireset = 1'b1;
        in_rst = 1'b1;
        sb.delete();
        @(negedge iclk);
        check("rst_ack", 32'(ofl_ack), 32'd0);
        check("rst_data", 32'(ofl_data), 32'd0);
        check("rst_a", 32'(ofl_a), 32'd0);
        check("rst_ce_oe", 32'({ofl_ce_n, ofl_oe_n}), 32'd3);
        check("rst_flash_rst_n", 32'(ofl_rst_n), 32'd0);
        check("rst_ordy", 32'(ordy), 32'd0);
        check("rst_we_wp", 32'({ofl_we_n, ofl_wp_n}), 32'd2);
        @(negedge iclk);
        ireset = 1'b0;
        in_rst = 1'b0;
        rel = cyc;
        rst_hi = -1;
        rdy_at = -1;
        ce_ok = 1'b1;
        for (int k = 0; k < 80 && rdy_at < 0; k++) begin
            @(negedge iclk);
            if (early_req && cyc == rel + 3) ifl_req = ~ifl_req;
            if (rst_hi < 0 && ofl_rst_n) rst_hi = cyc;
            if (ordy) rdy_at = cyc;
            else if (ofl_ce_n !== 1'b1) ce_ok = 1'b0;
        end
        check("rst_low_cycles", 32'(rst_hi - rel), 32'(RSTC));
        check("recovery_cycles", 32'(rdy_at - rst_hi), 32'(RSTC));
        check("ce_idle_before_rdy", 32'(ce_ok), 32'd1);
        if (ifl_req !== ofl_ack)
            sb.push_back('{ref_word(ifl_addr), ifl_req, rdy_at + 1 + LAT});
        wait_ack();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        ifl_addr = 23'h000200;
        do_reset(1'b1);
        do_read(23'h000200, 0);
        do_read(23'h0001A4, 0);
        do_read(23'h0001A6, 0);
        do_read(23'h7FFFFE, 0);
        do_read(23'h7FFFFF, 0);
        do_read(23'($urandom), 2);
        do_read(23'($urandom), 1);
        for (int n = 0; n < 40; n++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge iclk);
            do_read(23'($urandom), $urandom_range(0, 3));
        end
        if (ifl_req) do_read(23'($urandom), 0);
        // Abort in the second-byte phase; req stays high and must be served after ordy.
        ifl_addr = 23'h0012AB;
        ifl_req = 1'b1;
        repeat (ACC + 1) @(negedge iclk);
        check("abort_in_hi_phase", 32'({ofl_ce_n, ofl_a[0]}), 32'd1);
        do_reset(1'b0);
        do_read(23'h000200, 0);
        do_read(23'($urandom), 0);
        repeat (3) @(negedge iclk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
